module_display_scan: RTL and testbench



---
 rtl/module_display_scan.sv | 135 +++++++++++++
 tb/tb_module_display_scan.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/module_display_scan.sv
// module_display_scan: self-timed N-digit seven-segment scanner.
// A prescaler divides each digit slot into REFRESH_DIV cycles. The first
// GUARD_CYCLES of every slot keep all anodes off to prevent ghosting.
// Digit values sit in shadow registers and are latched once per slot, so a
// slot never shows a half-updated value.
// Optional feature macro: LEADING_ZERO_BLANK_EN. When it is defined, leading
// zero digits (value 0 with dp 0) keep their anodes dark; digit 0 is always lit.
module module_display_scan #(
  parameter int N_DIGITS         = 4,
  parameter int REFRESH_DIV      = 27000,
  parameter int GUARD_CYCLES     = 2,
  parameter int ANODE_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load_i,
  input  logic                  blank_i,
  output logic [N_DIGITS-1:0]   anodo_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [3:0]            digit_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  typedef enum logic {S_GUARD, S_DRIVE} state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               presc_q, presc_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        wrap;
  logic [N_DIGITS-1:0][3:0]    shadow_dig;
  logic [N_DIGITS-1:0]         shadow_dp;
  logic [3:0]                  cur_dig_d;
  logic                        cur_dp_d;
  logic                        lzb_d;
  logic [N_DIGITS-1:0]         anode_d;

  // hex nibble to {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_dec(input logic [3:0] v);
    case (v)
      4'h0: seg_dec = 7'h3F;  4'h1: seg_dec = 7'h06;
      4'h2: seg_dec = 7'h5B;  4'h3: seg_dec = 7'h4F;
      4'h4: seg_dec = 7'h66;  4'h5: seg_dec = 7'h6D;
      4'h6: seg_dec = 7'h7D;  4'h7: seg_dec = 7'h07;
      4'h8: seg_dec = 7'h7F;  4'h9: seg_dec = 7'h6F;
      4'hA: seg_dec = 7'h77;  4'hB: seg_dec = 7'h7C;
      4'hC: seg_dec = 7'h39;  4'hD: seg_dec = 7'h5E;
      4'hE: seg_dec = 7'h79;  default: seg_dec = 7'h71;
    endcase
  endfunction

  // prescaler/index advance; slot boundary is the prescaler wrap
  always_comb begin
    wrap    = (presc_q == PW'(REFRESH_DIV - 1));
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    // the new slot reads the shadow as it was before this edge's load
    cur_dig_d = wrap ? shadow_dig[idx_d] : digit_o;
    cur_dp_d  = wrap ? shadow_dp[idx_d]  : dp_o;
  end

  // guard/drive FSM, decided on the prescaler value the next cycle will hold
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GUARD: if (int'(presc_d) >= GUARD_CYCLES) state_d = S_DRIVE;
      default: if (int'(presc_d) <  GUARD_CYCLES) state_d = S_GUARD;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lzb_q;
  logic nz;

  // a slot is dark if it and every higher digit are zero with no dp
  always_comb begin
    nz = 1'b0;
    for (int k = 0; k < N_DIGITS; k++)
      if (k >= int'(idx_d) && (shadow_dig[k] != 4'd0 || shadow_dp[k])) nz = 1'b1;
    lzb_d = wrap ? ((idx_d != '0) && !nz) : lzb_q;
  end

  // leading-zero decision held for the whole slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lzb_q <= 1'b0;
    else        lzb_q <= lzb_d;
`else
  assign lzb_d = 1'b0;
`endif

  // anode drive for the coming cycle; blank only gates the anodes
  always_comb begin
    anode_d = AN_OFF;
    if (state_d == S_DRIVE && !blank_i && !lzb_d)
      anode_d = (N_DIGITS'(1) << idx_d) ^ AN_OFF;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_GUARD;
    else        state_q <= state_d;

  // scan counters, shadow registers and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      shadow_dig <= '0;
      shadow_dp  <= '0;
      anodo_o    <= AN_OFF;
      seg_o      <= '0;
      dp_o       <= 1'b0;
      digit_o    <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (load_i) begin
        shadow_dig <= digits_i;
        shadow_dp  <= dp_i;
      end
      anodo_o <= anode_d;
      seg_o   <= seg_dec(cur_dig_d);
      dp_o    <= cur_dp_d;
      digit_o <= cur_dig_d;
    end
  end

endmodule

// File: tb/tb_module_display_scan.sv
// Directed bench for module_display_scan: N=4, DIV=8, GUARD=2 active-high
// instance plus a GUARD=0 active-low instance sharing the same stimulus.
module tb_module_display_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0, blank = 1'b0;
  logic [3:0]  an, an2, dig, dig2;
  logic [6:0]  seg, seg2;
  logic        dpo, dpo2;
  int          checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  module_display_scan #(.N_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .ANODE_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits), .dp_i(dp), .load_i(load), .blank_i(blank),
    .anodo_o(an), .seg_o(seg), .dp_o(dpo), .digit_o(dig));

  module_display_scan #(.N_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(0), .ANODE_ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .digits_i(digits), .dp_i(dp), .load_i(load), .blank_i(blank),
    .anodo_o(an2), .seg_o(seg2), .dp_o(dpo2), .digit_o(dig2));

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] an2;
    logic [6:0] seg;
    logic [3:0] dig;
    logic       dp;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    tbl[0]  = '{1,  4'b0000, 4'b1110, 7'h3F, 4'h0, 1'b0};
    tbl[1]  = '{2,  4'b0001, 4'b1110, 7'h3F, 4'h0, 1'b0};
    tbl[2]  = '{7,  4'b0001, 4'b1110, 7'h3F, 4'h0, 1'b0};
    tbl[3]  = '{8,  4'b0000, 4'b1101, 7'h5B, 4'h2, 1'b0};
    tbl[4]  = '{10, 4'b0010, 4'b1101, 7'h5B, 4'h2, 1'b0};
    tbl[5]  = '{16, 4'b0000, 4'b1011, 7'h4F, 4'h3, 1'b1};
    tbl[6]  = '{18, 4'b0100, 4'b1011, 7'h4F, 4'h3, 1'b1};
    tbl[7]  = '{24, 4'b0000, 4'b0111, 7'h66, 4'h4, 1'b0};
    tbl[8]  = '{26, 4'b1000, 4'b0111, 7'h66, 4'h4, 1'b0};
    tbl[9]  = '{31, 4'b1000, 4'b0111, 7'h66, 4'h4, 1'b0};
    tbl[10] = '{32, 4'b0000, 4'b1110, 7'h06, 4'h1, 1'b0};
    tbl[11] = '{34, 4'b0001, 4'b1110, 7'h06, 4'h1, 1'b0};
    tbl[12] = '{40, 4'b0000, 4'b1101, 7'h5B, 4'h2, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'b0000);
    chk("rst_an2", an2, 4'b1111);
    chk("rst_seg", seg, 0);
    chk("rst_dig", dig, 0);
    chk("rst_dp", dpo, 0);

    // scan with 4321; capture on the first edge after release
    @(negedge clk);
    rst_n = 1'b1;
    digits = 16'h4321; dp = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) step();
      chk("scan_an", an, tbl[i].an);
      chk("scan_an2", an2, tbl[i].an2);
      chk("scan_seg", seg, tbl[i].seg);
      chk("scan_dig", dig, tbl[i].dig);
      chk("scan_dp", dpo, tbl[i].dp);
    end

    // load coinciding with slot 3 -> slot 0 boundary
    digits = 16'h0000; dp = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    while (cyc < 63) step();
    digits = 16'h000F; load = 1'b1;
    step();
    load = 1'b0;
    chk("bnd_seg_old", seg, 7'h3F);
    chk("bnd_an_guard", an, 4'b0000);
    while (cyc < 66) step();
    chk("bnd_an", an, 4'b0001);
    chk("bnd_seg_old2", seg, 7'h3F);
    while (cyc < 96) step();
    chk("bnd_seg_new", seg, 7'h71);
    chk("bnd_dig_new", dig, 4'hF);
    while (cyc < 98) step();
    chk("bnd_an_new", an, 4'b0001);

    // blank for 10 cycles starting mid-DRIVE of slot 0
    while (cyc < 100) step();
    chk("pre_blank_an", an, 4'b0001);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("blank_an", an, 4'b0000);
      if (cyc == 105) chk("blank_seg", seg, 7'h3F);
    end
    blank = 1'b0;
    step();
`ifdef LEADING_ZERO_BLANK_EN
    chk("unblank_an", an, 4'b0000);
    chk("unblank_an2", an2, 4'b1111);
`else
    chk("unblank_an", an, 4'b0010);
    chk("unblank_an2", an2, 4'b1101);
`endif
    step();
    chk("unblank_guard", an, 4'b0000);

    // asynchronous reset mid-DRIVE in slot 2
    while (cyc < 116) step();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'b0000);
    chk("arst_an2", an2, 4'b1111);
    chk("arst_seg", seg, 0);
    chk("arst_dig", dig, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    step();
    chk("rel_an", an, 4'b0000);
    chk("rel_seg", seg, 7'h3F);
    chk("rel_an2", an2, 4'b1110);
    step();
    chk("rel_an_drive", an, 4'b0001);

`ifdef LEADING_ZERO_BLANK_EN
    // leading-zero blanking with 0050
    digits = 16'h0050; dp = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    while (cyc < 10) step();
    chk("lzb_an1", an, 4'b0010);
    chk("lzb_seg1", seg, 7'h6D);
    while (cyc < 18) step();
    chk("lzb_an2", an, 4'b0000);
    chk("lzb_seg2", seg, 7'h3F);
    chk("lzb_al2", an2, 4'b1111);
    while (cyc < 26) step();
    chk("lzb_an3", an, 4'b0000);
    while (cyc < 34) step();
    chk("lzb_an0", an, 4'b0001);
    digits = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;
    while (cyc < 42) step();
    chk("lzb_zero_an1", an, 4'b0000);
    while (cyc < 66) step();
    chk("lzb_zero_an0", an, 4'b0001);
    chk("lzb_zero_seg0", seg, 7'h3F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
